// File: rtl/alert_sequencer.sv
// Reminder alert sequencer: IDLE -> ALERT -> ESCALATE, with a debounced acknowledge that snoozes the alert.
// Optional feature macro ALERT_BUZZER_EN: when defined the buzzer toggles in ESCALATE, otherwise it stays 0.
module alert_sequencer #(
  parameter int ESCALATE_TICKS  = 60,
  parameter int SNOOZE_TICKS    = 300,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       remind,
  input  logic       ack_n,
  output logic       led,
  output logic       buzzer,
  output logic       alert_active,
  output logic [3:0] snooze_count,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_ALERT  = 2'b01,
    S_ESC    = 2'b10,
    S_SNOOZE = 2'b11
  } state_t;

  localparam logic [7:0]  DB_LAST  = 8'(DEBOUNCE_CYCLES - 1);
  localparam logic [15:0] ESC_LAST = 16'(ESCALATE_TICKS - 1);
  localparam logic [15:0] SNZ_LAST = 16'(SNOOZE_TICKS - 1);

  logic [1:0]  sync_q;
  logic [1:0]  vld_q;
  logic        level_q, level_d;
  logic [7:0]  db_cnt_q, db_cnt_d;
  logic [7:0]  rel_cnt_q, rel_cnt_d;
  logic        armed_q, armed_d;
  logic        press_q, press_d;
  logic        ack_s;
  logic        sample_ok;

  state_t      state_q, state_d;
  logic [15:0] tcnt_q, tcnt_d;
  logic        led_q, led_d;
  logic        buz_q, buz_d;
  logic        active_q, active_d;
  logic [3:0]  snz_q, snz_d;
  logic        entering;

  assign ack_s     = sync_q[1];
  assign sample_ok = vld_q[1];

  // Synchronizer samples are only trusted once real input has reached the second flop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= 2'b11;
      vld_q  <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], ack_n};
      vld_q  <= {vld_q[0], 1'b1};
    end
  end

  // Press events need a confirmed release first, so a button held through reset never fires.
  always_comb begin
    level_d   = level_q;
    db_cnt_d  = db_cnt_q;
    rel_cnt_d = rel_cnt_q;
    armed_d   = armed_q;
    press_d   = 1'b0;
    if (sample_ok) begin
      if (ack_s == level_q) begin
        db_cnt_d = 8'd0;
      end else if (db_cnt_q == DB_LAST) begin
        level_d  = ack_s;
        db_cnt_d = 8'd0;
        press_d  = armed_q & level_q & ~ack_s;
      end else begin
        db_cnt_d = db_cnt_q + 8'd1;
      end
      if (!armed_q) begin
        if (!ack_s) begin
          rel_cnt_d = 8'd0;
        end else if (rel_cnt_q == DB_LAST) begin
          armed_d = 1'b1;
        end else begin
          rel_cnt_d = rel_cnt_q + 8'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      level_q   <= 1'b1;
      db_cnt_q  <= 8'd0;
      rel_cnt_q <= 8'd0;
      armed_q   <= 1'b0;
      press_q   <= 1'b0;
    end else begin
      level_q   <= level_d;
      db_cnt_q  <= db_cnt_d;
      rel_cnt_q <= rel_cnt_d;
      armed_q   <= armed_d;
      press_q   <= press_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (remind) state_d = S_ALERT;
      end
      S_ALERT: begin
        if (!remind)                        state_d = S_IDLE;
        else if (press_q)                   state_d = S_SNOOZE;
        else if (tick && tcnt_q == ESC_LAST) state_d = S_ESC;
      end
      S_ESC: begin
        if (!remind)      state_d = S_IDLE;
        else if (press_q) state_d = S_SNOOZE;
      end
      default: begin
        if (!remind)                         state_d = S_IDLE;
        else if (tick && tcnt_q == SNZ_LAST) state_d = S_ALERT;
      end
    endcase
  end

  assign entering = (state_d != state_q);

  // Outputs are computed from the next state so they change on the same edge as state.
  always_comb begin
    tcnt_d   = tcnt_q;
    led_d    = 1'b0;
    buz_d    = 1'b0;
    snz_d    = snz_q;
    active_d = (state_d == S_ALERT) || (state_d == S_ESC);
    if (entering) begin
      tcnt_d = 16'd0;
    end else if (tick && (state_q == S_ALERT || state_q == S_SNOOZE)) begin
      tcnt_d = tcnt_q + 16'd1;
    end
    case (state_d)
      S_IDLE: begin
        snz_d = 4'd0;
      end
      S_ALERT: begin
        if (entering)  led_d = 1'b1;
        else if (tick) led_d = ~led_q;
        else           led_d = led_q;
      end
      S_ESC: begin
        led_d = 1'b1;
`ifdef ALERT_BUZZER_EN
        if (entering)  buz_d = 1'b1;
        else if (tick) buz_d = ~buz_q;
        else           buz_d = buz_q;
`else
        buz_d = 1'b0;
`endif
      end
      default: begin
        if (entering && snz_q != 4'd15) snz_d = snz_q + 4'd1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      tcnt_q   <= 16'd0;
      led_q    <= 1'b0;
      buz_q    <= 1'b0;
      active_q <= 1'b0;
      snz_q    <= 4'd0;
    end else begin
      state_q  <= state_d;
      tcnt_q   <= tcnt_d;
      led_q    <= led_d;
      buz_q    <= buz_d;
      active_q <= active_d;
      snz_q    <= snz_d;
    end
  end

  assign led          = led_q;
  assign buzzer       = buz_q;
  assign alert_active = active_q;
  assign snooze_count = snz_q;
  assign state        = state_q;

endmodule

// File: tb/tb_alert_sequencer.sv
// Directed bench for alert_sequencer with ESCALATE_TICKS=3, SNOOZE_TICKS=2, DEBOUNCE_CYCLES=4.
module tb_alert_sequencer;

`ifdef ALERT_BUZZER_EN
  localparam logic BUZ_EN = 1'b1;
`else
  localparam logic BUZ_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       tick = 1'b0;
  logic       remind = 1'b0;
  logic       ack_n = 1'b1;
  logic       led, buzzer, alert_active;
  logic [3:0] snooze_count;
  logic [1:0] state;

  int checks = 0;
  int passes = 0;

  alert_sequencer #(
    .ESCALATE_TICKS(3),
    .SNOOZE_TICKS(2),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .tick(tick),
    .remind(remind),
    .ack_n(ack_n),
    .led(led),
    .buzzer(buzzer),
    .alert_active(alert_active),
    .snooze_count(snooze_count),
    .state(state)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_tick();
    tick = 1'b1;
    step(1);
    tick = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; remind = 1'b0; ack_n = 1'b1;
    step(2);
    checks++;
    if ({state, led, buzzer, alert_active, snooze_count} !== 9'd0)
      $display("FAIL reset_outputs: got state=%b led=%b buz=%b act=%b snz=%0d, want all 0",
               state, led, buzzer, alert_active, snooze_count);
    else passes++;
    reset = 1'b1;
    remind = 1'b1;
    step(1);
    checks++;
    if (state !== 2'b01 || led !== 1'b1 || alert_active !== 1'b1 || buzzer !== 1'b0)
      $display("FAIL first_alert: got state=%b led=%b act=%b buz=%b, want 01 1 1 0",
               state, led, alert_active, buzzer);
    else passes++;
    $display("[tb] test_reset done state=%b", state);
  endtask

  task automatic test_ack();
    bit seen;
    int lat;
    step(8);
    seen = 1'b0; lat = 0;
    ack_n = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      step(1);
      if (!seen && state == 2'b11) begin
        seen = 1'b1;
        lat = c;
      end
    end
    ack_n = 1'b1;
    checks++;
    if (!seen || lat > 7)
      $display("FAIL ack_latency: got seen=%0d latency=%0d, want seen=1 latency<=7", seen, lat);
    else passes++;
    checks++;
    if (snooze_count !== 4'd1 || led !== 1'b0 || alert_active !== 1'b0)
      $display("FAIL ack_snooze: got snz=%0d led=%b act=%b, want 1 0 0", snooze_count, led, alert_active);
    else passes++;
    step(8);
    do_tick();
    checks++;
    if (state !== 2'b11)
      $display("FAIL snooze_tick1: got state=%b, want 11", state);
    else passes++;
    do_tick();
    checks++;
    if (state !== 2'b01 || led !== 1'b1 || snooze_count !== 4'd1)
      $display("FAIL snooze_expire: got state=%b led=%b snz=%0d, want 01 1 1", state, led, snooze_count);
    else passes++;
    $display("[tb] test_ack done latency=%0d", lat);
  endtask

  task automatic test_escalate();
    do_tick();
    checks++;
    if (state !== 2'b01 || led !== 1'b0)
      $display("FAIL led_tick1: got state=%b led=%b, want 01 0", state, led);
    else passes++;
    do_tick();
    checks++;
    if (state !== 2'b01 || led !== 1'b1)
      $display("FAIL led_tick2: got state=%b led=%b, want 01 1", state, led);
    else passes++;
    do_tick();
    checks++;
    if (state !== 2'b10 || led !== 1'b1 || buzzer !== BUZ_EN || alert_active !== 1'b1)
      $display("FAIL escalate_entry: got state=%b led=%b buz=%b act=%b, want 10 1 %b 1",
               state, led, buzzer, alert_active, BUZ_EN);
    else passes++;
    do_tick();
    checks++;
    if (state !== 2'b10 || led !== 1'b1 || buzzer !== 1'b0)
      $display("FAIL escalate_toggle: got state=%b led=%b buz=%b, want 10 1 0", state, led, buzzer);
    else passes++;
    $display("[tb] test_escalate done state=%b", state);
  endtask

  task automatic test_glitch();
    ack_n = 1'b0;
    step(3);
    ack_n = 1'b1;
    step(10);
    checks++;
    if (state !== 2'b10 || snooze_count !== 4'd1)
      $display("FAIL glitch: got state=%b snz=%0d, want 10 1", state, snooze_count);
    else passes++;
    $display("[tb] test_glitch done state=%b", state);
  endtask

  task automatic test_remind_priority();
    ack_n = 1'b0;
    step(6);
    remind = 1'b0;
    step(1);
    checks++;
    if ({state, led, buzzer, alert_active, snooze_count} !== 9'd0)
      $display("FAIL remind_priority: got state=%b led=%b buz=%b act=%b snz=%0d, want all 0",
               state, led, buzzer, alert_active, snooze_count);
    else passes++;
    ack_n = 1'b1;
    step(8);
    $display("[tb] test_remind_priority done state=%b", state);
  endtask

  task automatic test_saturate();
    int exp;
    remind = 1'b1;
    step(1);
    for (int i = 0; i < 17; i++) begin
      ack_n = 1'b0;
      step(8);
      exp = (i + 1 > 15) ? 15 : i + 1;
      checks++;
      if (state !== 2'b11 || snooze_count !== 4'(exp))
        $display("FAIL saturate_%0d: got state=%b snz=%0d, want 11 %0d", i, state, snooze_count, exp);
      else passes++;
      ack_n = 1'b1;
      step(7);
      do_tick();
      do_tick();
    end
    remind = 1'b0;
    step(1);
    checks++;
    if (state !== 2'b00 || snooze_count !== 4'd0)
      $display("FAIL saturate_clear: got state=%b snz=%0d, want 00 0", state, snooze_count);
    else passes++;
    $display("[tb] test_saturate done snz=%0d", snooze_count);
  endtask

  task automatic test_reset_mid();
    remind = 1'b1;
    step(1);
    do_tick(); do_tick(); do_tick();
    checks++;
    if (state !== 2'b10)
      $display("FAIL reset_mid_setup: got state=%b, want 10", state);
    else passes++;
    ack_n = 1'b0;
    step(2);
    #3;
    reset = 1'b0;
    #1;
    checks++;
    if ({state, led, buzzer, alert_active, snooze_count} !== 9'd0)
      $display("FAIL reset_async: got state=%b led=%b buz=%b act=%b snz=%0d, want all 0",
               state, led, buzzer, alert_active, snooze_count);
    else passes++;
    step(2);
    reset = 1'b1;
    step(1);
    checks++;
    if (state !== 2'b01)
      $display("FAIL reset_reenter: got state=%b, want 01", state);
    else passes++;
    step(15);
    checks++;
    if (state !== 2'b01 || snooze_count !== 4'd0)
      $display("FAIL reset_no_press: got state=%b snz=%0d, want 01 0", state, snooze_count);
    else passes++;
    ack_n = 1'b1;
    step(8);
    $display("[tb] test_reset_mid done state=%b", state);
  endtask

  initial begin
    test_reset();
    test_ack();
    test_escalate();
    test_glitch();
    test_remind_priority();
    test_saturate();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
